// File: rtl/dmem_lsu.sv
// dmem_lsu: byte/half/word load-store unit with read-modify-write over a word-only synchronous memory.
// Define DMEM_LSU_BOUNDS_CHECK_EN to fault word indices at or beyond DEPTH_WORDS.
module dmem_lsu #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_wen,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_unsigned,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_fault,
  output logic        o_mem_we,
  output logic        o_mem_re,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wd,
  input  logic [31:0] i_mem_rd
);
  localparam int AW = $clog2(DEPTH_WORDS);
  typedef enum logic [2:0] {IDLE, READ, LRESP, MERGE, RESP} state_t;
  state_t state, state_nx;
  logic          wen_q, uns_q, fault_q, accept, req_fault, oob;
  logic [1:0]    size_q, off_q;
  logic [AW-1:0] idx_q;
  logic [31:0]   wdata_q, lane_m, mask, ins, merged, ext;
  logic [4:0]    sh;
  logic [7:0]    lane_b;
  logic [15:0]   lane_h;
`ifdef DMEM_LSU_BOUNDS_CHECK_EN
  assign oob = {2'b00, i_req_addr[31:2]} >= 32'(DEPTH_WORDS);
`else
  logic unused_addr;
  assign unused_addr = ^i_req_addr[31:AW+2];
  assign oob = 1'b0;
`endif
  assign accept    = i_req_valid & o_req_ready;
  assign req_fault = (i_req_size == 2'b11) | ((i_req_size == 2'b01) & i_req_addr[0]) |
                     ((i_req_size == 2'b10) & |i_req_addr[1:0]) | oob;
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk)
    if (accept) begin
      wen_q   <= i_req_wen;
      idx_q   <= i_req_addr[AW+1:2];
      off_q   <= i_req_addr[1:0];
      wdata_q <= i_req_wdata;
      size_q  <= i_req_size;
      uns_q   <= i_req_unsigned;
      fault_q <= req_fault;
    end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = !accept ? IDLE : req_fault ? RESP :
                          (i_req_wen & (i_req_size == 2'b10)) ? MERGE : READ;
      READ:    state_nx = wen_q ? MERGE : LRESP;
      MERGE:   state_nx = RESP;
      default: state_nx = IDLE;
    endcase
  end
  // Lane shift/mask shared by load extraction and store merge.
  assign sh     = size_q == 2'b00 ? {off_q, 3'b000} : {off_q[1], 4'b0000};
  assign lane_m = size_q == 2'b00 ? 32'h0000_00ff : 32'h0000_ffff;
  assign mask   = lane_m << sh;
  assign ins    = (wdata_q & lane_m) << sh;
  assign merged = size_q == 2'b10 ? wdata_q : (i_mem_rd & ~mask) | ins;
  assign lane_b = 8'(i_mem_rd >> sh);
  assign lane_h = off_q[1] ? i_mem_rd[31:16] : i_mem_rd[15:0];
  assign ext    = size_q == 2'b00 ? {{24{~uns_q & lane_b[7]}}, lane_b} :
                  size_q == 2'b01 ? {{16{~uns_q & lane_h[15]}}, lane_h} : i_mem_rd;
  assign o_req_ready = (state == IDLE) & !rst;
  assign o_mem_re    = (state == READ) & !rst;
  assign o_mem_we    = (state == MERGE) & !rst;
  assign o_mem_addr  = ((state == READ) | (state == MERGE)) & !rst ? {{(32-AW){1'b0}}, idx_q} : 32'd0;
  assign o_mem_wd    = o_mem_we ? merged : 32'd0;
  assign o_rsp_valid = ((state == RESP) | (state == LRESP)) & !rst;
  assign o_rsp_fault = (state == RESP) & fault_q & !rst;
  assign o_rsp_rdata = (state == LRESP) & !rst ? ext : 32'd0;
endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Load/store unit between the hart's data port and the word-addressed, synchronous-read data memory. Accepts byte-addressed byte/halfword/word loads and stores, converts them to word-index memory accesses, and sign- or zero-extends load data. Performs read-modify-write for sub-word stores because the memory has no byte enables. Reports misaligned and unsupported accesses as faults without touching memory.

## Interface
- DEPTH_WORDS, 1024, memory depth in 32-bit words; power of two.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- i_req_valid  in  1  request present.
- o_req_ready  out  1  LSU can accept; request taken in a cycle with valid&ready.
- i_req_wen  in  1  1 = store, 0 = load.
- i_req_addr  in  32  byte address.
- i_req_wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- i_req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- i_req_unsigned  in  1  zero-extend load (LBU/LHU); ignored for stores and words.
- o_rsp_valid  out  1  one-cycle completion pulse.
- o_rsp_rdata  out  32  extended load data; 0 for stores and faults.
- o_rsp_fault  out  1  access rejected; valid only with o_rsp_valid.
- o_mem_we  out  1  memory write enable.
- o_mem_re  out  1  memory read enable.
- o_mem_addr  out  32  word index, zero-extended.
- o_mem_wd  out  32  memory write data.
- i_mem_rd  in  32  memory read data, valid the cycle after o_mem_re.

## Operation
- States: IDLE, READ, LRESP, MERGE, RESP.
- On accept, latch wen, addr, wdata, size, unsigned. off = addr[1:0], idx = addr[31:2].
- Fault if size==11, or size==01 and off[0]==1, or size==10 and off!=0. Fault path: IDLE→RESP; no mem access; rsp_fault=1, rdata=0.
- Word store: IDLE→MERGE, o_mem_wd = wdata, →RESP.
- Load: IDLE→READ (re=1) →LRESP (rsp_valid=1, rdata from i_mem_rd) →IDLE.
- Sub-word store: IDLE→READ (re=1) →MERGE (we=1, o_mem_wd = i_mem_rd with lane replaced) →RESP →IDLE.
- Lanes: byte = rd[8*off+7:8*off]; half = off[1] ? rd[31:16] : rd[15:0]. Merge replaces the same lanes with wdata[7:0] / wdata[15:0]; other bits unchanged.
- Extension: sign-extend bit 7/15 unless unsigned=1.
- o_mem_addr = idx in READ/MERGE, 0 otherwise; o_mem_wd = 0 outside MERGE.
- o_req_ready = (state==IDLE) & !rst. Only one request in flight.

## Timing
- Accept in cycle C. Fault: rsp_valid at C+1. Word store: we at C+1, rsp at C+2. Load: re at C+1, rsp at C+2. Sub-word store: re at C+1, we at C+2, rsp at C+3.
- Next accept possible the cycle after rsp_valid (return to IDLE).
- Memory outputs and rsp outputs are decoded from registered state/latched fields; no combinational path from i_req_* to o_mem_*.
- Reset: state→IDLE; outputs rsp_valid=0, rsp_fault=0, rdata=0, mem_we=0, mem_re=0, mem_addr=0, mem_wd=0, req_ready=0 while rst high, 1 the cycle after.
- Reset mid-operation aborts: o_mem_we and o_mem_re gated by !rst, so no write occurs in a cycle with rst high; no response is issued for the aborted request.
- i_req_* changes while not accepted are ignored.

## Configuration
- DMEM_LSU_BOUNDS_CHECK_EN defined: idx >= DEPTH_WORDS faults (same path as misalignment, no mem access).
- Not defined: no range check; o_mem_addr = idx modulo DEPTH_WORDS (low log2(DEPTH_WORDS) bits, upper bits 0).

## Test plan
- Store word 0xDEADBEEF to 0x10, load word 0x10 -> we at C+1 with addr 4; load rsp at C+2 rdata 0xDEADBEEF, fault 0.
- Store byte 0x80 to 0x13 over 0xDEADBEEF -> mem word 4 = 0x80ADBEEF; LB 0x13 -> 0xFFFFFF80; LBU 0x13 -> 0x00000080.
- Store half 0x1234 to 0x22 over 0 -> word 8 = 0x12340000; LH 0x22 -> 0x00001234; rsp at C+3 for the store.
- LW 0x11, LH 0x21, size 11 -> rsp at C+1, fault 1, rdata 0, re/we never asserted.
- With DMEM_LSU_BOUNDS_CHECK_EN, LW 0x1000 (DEPTH 1024) -> fault 1; without, access hits word 0.
- Assert rst during MERGE of SB -> no write observed, no rsp_valid, ready=1 the cycle after rst drops.
